// File: rtl/uart_transmit_pkg.sv
// Shared UART definitions: frame geometry, FSM state encodings and the
// clk_div interpretation used by both the transmitter and the receiver.
package uart_transmit_pkg;

  // Data bits per frame and total bits per frame (start + data + stop).
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // 4-bit encoding so the receiver's state register has the same width.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_STOP  = 4'd3,
    ST_DONE  = 4'd4
  } uart_state_e;

  // A divisor of zero would never produce a tick; treat it as one cycle per bit.
  function automatic logic [31:0] div_eff(input logic [31:0] clk_div);
    return (clk_div == 32'd0) ? 32'd1 : clk_div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: while enabled, counts clk cycles and emits a one-cycle
// tick on the last cycle of every div_i-cycle bit period. Restarts from zero
// whenever it is disabled, so the first period after enabling is full length.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] div_i,
  output logic        tick_o
);

  logic [31:0] clk_cnt_q;
  logic [31:0] clk_cnt_d;

  // div_i is always at least 1, so div_i-1 never underflows.
  assign tick_o = en_i && (clk_cnt_q == (div_i - 32'd1));

  // Next count: hold at zero when idle, wrap to zero at the end of a period.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    if (!en_i) begin
      clk_cnt_d = 32'd0;
    end else if (tick_o) begin
      clk_cnt_d = 32'd0;
    end else begin
      clk_cnt_d = clk_cnt_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q <= 32'd0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter. Accepts a byte on a tx_start pulse while idle and
// shifts it out LSB first between a low start bit and a high stop bit, each
// bit lasting the divisor captured at frame start. All outputs are registered
// and are computed from the next state so they change together with it.
module uart_transmit
  import uart_transmit_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          clk_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 tx_clear,
  output logic                 tx,
  output logic                 busy,
  output logic                 irq
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [31:0]          div_q, div_d;

  logic                 baud_en;
  logic                 baud_tick;

  // The bit timer only runs while a bit is actually on the line.
  assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

  uart_baud_tick u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (baud_en),
    .div_i  (div_q),
    .tick_o (baud_tick)
  );

  // Next-state and registered-output logic; the FSM advances only on baud_tick.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    irq_d     = irq_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_d     = div_q;

    // Acknowledge from the bus; a completion in DONE below overrides it.
    if (tx_clear) begin
      irq_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          irq_d   = 1'b0;
          shift_d = tx_data;
          div_d   = div_eff(clk_div);
        end
      end

      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          // busy drops as the stop bit ends, so it spans exactly ten bit periods.
          state_d = ST_DONE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end

      ST_DONE: begin
        // tx_start is not looked at here; a request in this cycle is dropped.
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        irq_d   = 1'b1;
      end

      default: begin
        state_d   = ST_IDLE;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        irq_d     = 1'b0;
        bit_idx_d = '0;
        shift_d   = '0;
        div_d     = 32'd1;
      end
    endcase
  end

  // State and output registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_q     <= 32'd1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit. Accepted frames are pushed to a
// scoreboard when tx_start is driven; each test pops the expected frame and
// compares the cycle-by-cycle line trace against a reference frame model.
module tb_uart_transmit;
  import uart_transmit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clk_div = 32'd4;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_start = 1'b0;
  logic        tx_clear = 1'b0;
  logic        tx;
  logic        busy;
  logic        irq;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_transmit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_div  (clk_div),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_clear (tx_clear),
    .tx       (tx),
    .busy     (busy),
    .irq      (irq)
  );

  // Reference line level for every clk cycle of a frame.
  function automatic logic [159:0] model_trace(input logic [7:0] d, input int div);
    logic [159:0] t;
    t = '0;
    for (int c = 0; c < UART_FRAME_BITS * div; c++) begin
      int k;
      k = c / div;
      if (k == 0) t[c] = 1'b0;
      else if (k == UART_FRAME_BITS - 1) t[c] = 1'b1;
      else t[c] = d[k-1];
    end
    return t;
  endfunction

  // Pulse tx_start for one cycle (called at a negedge, returns at the next one).
  task automatic send(input logic [7:0] d, input logic [31:0] div, input bit accepted);
    tx_data  = d;
    clk_div  = div;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    if (accepted) sb.push_back('{d, (div == 32'd0) ? 1 : int'(div)});
  endtask

  // Record the line from the first low cycle for one whole frame.
  task automatic capture(input int div, output logic [159:0] trace, output int busy_cnt,
                         output bit to);
    int w;
    w = 0;
    trace = '0;
    busy_cnt = 0;
    to = 1'b0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      to = 1'b1;
    end else begin
      for (int c = 0; c < UART_FRAME_BITS * div; c++) begin
        trace[c] = tx;
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_clear();
    tx_clear = 1'b1;
    @(negedge clk);
    tx_clear = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_line bad_cycles=%0d want=0", bad); end
    $display("reset: idle line checked for 100 cycles");
  endtask

  task automatic test_basic();
    frame_t e; logic [159:0] tr; int bc; bit to;
    send(8'hA5, 32'd4, 1'b1);
    e = sb.pop_front();
    capture(e.div, tr, bc, to);
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL basic_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    n_cmp++; if (bc !== 40) begin n_bad++; $display("FAIL basic_busy_len got=%0d want=40", bc); end
    n_cmp++; if (busy !== 1'b0 || irq !== 1'b0) begin n_bad++;
      $display("FAIL basic_done_cycle busy=%b irq=%b want busy=0 irq=0", busy, irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq_set got=%b want=1", irq); end
    pulse_clear();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_clear got=%b want=0", irq); end
  endtask

  task automatic test_div_one();
    frame_t e; logic [159:0] tr; int bc; bit to; int bad;
    send(8'hFF, 32'd1, 1'b1);
    e = sb.pop_front();
    capture(e.div, tr, bc, to);
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL div1_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    n_cmp++; if (bc !== 10) begin n_bad++; $display("FAIL div1_busy_len got=%0d want=10", bc); end
    // Request during the completion cycle must be dropped.
    send(8'h00, 32'd1, 1'b0);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL div1_irq got=%b want=1", irq); end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL done_start_ignored bad_cycles=%0d want=0", bad); end
    pulse_clear();
  endtask

  task automatic test_div_zero();
    frame_t e; logic [159:0] tr; int bc; bit to;
    send(8'h5A, 32'd0, 1'b1);
    e = sb.pop_front();
    capture(e.div, tr, bc, to);
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL div0_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    n_cmp++; if (bc !== 10) begin n_bad++; $display("FAIL div0_busy_len got=%0d want=10", bc); end
    // Clear coinciding with completion: the set wins.
    pulse_clear();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear got=%b want=1", irq); end
    pulse_clear();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL div0_irq_clear got=%b want=0", irq); end
  endtask

  task automatic test_busy_protect();
    frame_t e; logic [159:0] tr; int bc; bit to; int bad_tx; int bad_irq;
    send(8'h3C, 32'd8, 1'b1);
    e = sb.pop_front();
    fork
      capture(e.div, tr, bc, to);
      begin
        repeat (19) @(negedge clk);
        send(8'h55, 32'd8, 1'b0);
      end
    join
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL busy_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL busy_irq got=%b want=1", irq); end
    pulse_clear();
    bad_tx = 0;
    bad_irq = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (irq !== 1'b0) bad_irq++;
    end
    n_cmp++; if (bad_tx !== 0) begin n_bad++; $display("FAIL no_second_frame bad_cycles=%0d want=0", bad_tx); end
    n_cmp++; if (bad_irq !== 0) begin n_bad++; $display("FAIL single_irq irq_cycles=%0d want=0", bad_irq); end
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_empty size=%0d want=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    frame_t e; logic [159:0] tr; int bc; bit to;
    send(8'h96, 32'd8, 1'b1);
    e = sb.pop_front();
    fork
      capture(e.div, tr, bc, to);
      begin
        repeat (15) @(negedge clk);
        clk_div = 32'd3;
      end
    join
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL middiv_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq_pending got=%b want=1", irq); end
    send(8'h69, 32'd3, 1'b1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL start_clears_irq got=%b want=0", irq); end
    e = sb.pop_front();
    capture(e.div, tr, bc, to);
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL b2b_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    n_cmp++; if (bc !== 30) begin n_bad++; $display("FAIL b2b_busy_len got=%0d want=30", bc); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq got=%b want=1", irq); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t e; logic [159:0] tr; int bc; bit to; int bad;
    // irq is still pending from the previous frame; reset must clear it too.
    send(8'h30, 32'd4, 1'b0);
    repeat (16) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL bit3_level got=%b want=0", tx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || irq !== 1'b0) begin n_bad++;
      $display("FAIL async_reset tx=%b busy=%b irq=%b want 1/0/0", tx, busy, irq); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (irq !== 1'b0 || tx !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL abandoned_frame bad_cycles=%0d want=0", bad); end
    $display("reset mid-frame: frame data=30 abandoned");
    send(8'hE7, 32'd2, 1'b1);
    e = sb.pop_front();
    capture(e.div, tr, bc, to);
    $display("frame data=%h div=%0d busy_cycles=%0d", e.data, e.div, bc);
    n_cmp++; if (to || tr !== model_trace(e.data, e.div)) begin n_bad++;
      $display("FAIL post_reset_trace got=%h want=%h timeout=%0d", tr, model_trace(e.data, e.div), to); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL post_reset_irq got=%b want=1", irq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_one();
    test_div_zero();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
